// File: rtl/spi_ram_pkg.sv
// Shared types and command-byte layout for the SPI-to-RAM bridge.
// The FSM state encoding lives here so the top module and any debug tooling use the same values.
`timescale 1ns/1ps
package spi_ram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    WDATA,
    WR_SETUP,
    RD_SETUP,
    PULSE,
    HOLD,
    RDATA,
    DONE
  } state_t;

  localparam int CMD_BITS      = 8;
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_LSB  = 0;

endpackage

// File: rtl/spi_ram_bridge_if.sv
// RAM-side bus between the SPI bridge and the RAM multiplexer's SPI port.
// The bridge is the master; the multiplexer (or a RAM model) is the slave.
`timescale 1ns/1ps
interface spi_ram_bridge_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              ram_clk;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (output ram_clk, ram_we, ram_addr, ram_wdata, input ram_rdata);
  modport slave  (input ram_clk, ram_we, ram_addr, ram_wdata, output ram_rdata);
endinterface

// File: rtl/spi_ram_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall detect on the synced value.
// RST_VAL lets active-low inputs (CS_N) come out of reset in their inactive level.
`timescale 1ns/1ps
module spi_ram_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI mode-0 target that turns command+data frames into single-cycle RAM pulses on the mux SPI port.
// Define SPI_RAM_BURST_EN for streaming bursts (address auto-increments, frame ends only on CS deassert).
//
// state    | meaning
// IDLE     | waiting for CS; bit counter cleared
// CMD      | shifting in the 8-bit command byte
// WDATA    | shifting in a DATA_W-bit write word
// WR_SETUP | addr/data/we driven, RAM clock low
// RD_SETUP | addr driven, RAM clock low
// PULSE    | RAM clock high for exactly one cycle
// HOLD     | RAM clock low, read data captured into TX shifter
// RDATA    | shifting read word out on MISO
// DONE     | frame finished, waiting for CS deassert
`timescale 1ns/1ps
module spi_ram_bridge
  import spi_ram_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             sck_i,
  input  logic             cs_n_i,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             spi_cs_o,
  output logic             busy_o,
  spi_ram_bridge_if.master ram
);

`ifdef SPI_RAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_s;

  spi_ram_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d(sck_i), .q(sck_s), .rise(sck_rise), .fall(sck_fall));
  spi_ram_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d(cs_n_i), .q(cs_n_s), .rise(cs_rise), .fall(cs_fall));
  spi_ram_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d(mosi_i), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  assign cs_s = ~cs_n_s;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CMD_BITS-2:0]   cmd_q;
  logic [CMD_BITS-1:0]   cmd_next;
  logic [DATA_W-1:0]     rx_q;
  logic [DATA_W-1:0]     tx_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  is_write_q;
  logic                  last_cmd_bit;
  logic                  last_data_bit;

  assign cmd_next      = {cmd_q, mosi_s};
  assign last_cmd_bit  = sck_rise && (bit_cnt_q == CNT_W'(CMD_BITS - 1));
  assign last_data_bit = sck_rise && (bit_cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Once an access has started it always runs SETUP->PULSE->HOLD so the RAM pulse is never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cs_s) state_d = CMD;
      CMD: begin
        if (!cs_s)             state_d = IDLE;
        else if (last_cmd_bit) state_d = cmd_next[CMD_WRITE_BIT] ? WDATA : RD_SETUP;
      end
      WDATA: begin
        if (!cs_s)              state_d = IDLE;
        else if (last_data_bit) state_d = WR_SETUP;
      end
      WR_SETUP: state_d = PULSE;
      RD_SETUP: state_d = PULSE;
      PULSE:    state_d = HOLD;
      HOLD: begin
        if (!cs_s)           state_d = IDLE;
        else if (is_write_q) state_d = BURST ? WDATA : DONE;
        else                 state_d = RDATA;
      end
      RDATA: begin
        if (!cs_s)              state_d = IDLE;
        else if (last_data_bit) state_d = BURST ? RD_SETUP : DONE;
      end
      DONE:     if (!cs_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      is_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: bit_cnt_q <= '0;
        CMD: if (sck_rise) begin
          cmd_q     <= cmd_next[CMD_BITS-2:0];
          bit_cnt_q <= last_cmd_bit ? '0 : bit_cnt_q + CNT_W'(1);
          if (last_cmd_bit) begin
            is_write_q <= cmd_next[CMD_WRITE_BIT];
            addr_q     <= cmd_next[CMD_ADDR_LSB +: ADDR_W];
          end
        end
        WDATA: if (sck_rise) begin
          rx_q      <= {rx_q[DATA_W-2:0], mosi_s};
          bit_cnt_q <= last_data_bit ? '0 : bit_cnt_q + CNT_W'(1);
        end
        HOLD: begin
          if (!is_write_q) tx_q <= ram.ram_rdata;
          if (BURST) addr_q <= addr_q + ADDR_W'(1);
          bit_cnt_q <= '0;
        end
        RDATA: begin
          // Bit DATA_W-1 is already on MISO; the first falling edge precedes its sampling edge.
          if (sck_rise)
            bit_cnt_q <= last_data_bit ? '0 : bit_cnt_q + CNT_W'(1);
          else if (sck_fall && bit_cnt_q != '0)
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign ram.ram_clk   = (state_q == PULSE);
  assign ram.ram_we    = is_write_q && (state_q inside {WR_SETUP, PULSE, HOLD});
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = rx_q;

  assign miso_o   = (state_q == RDATA) && tx_q[DATA_W-1];
  assign spi_cs_o = cs_s;

  // IDLE with CS already asserted counts as frame start, so busy stays high across a HOLD->IDLE->CMD restart.
  always_comb begin
    busy_o = 1'b1;
    case (state_q)
      IDLE:    busy_o = cs_s;
      DONE:    busy_o = 1'b0;
      RDATA:   busy_o = BURST;
      default: busy_o = 1'b1;
    endcase
  end

  logic unused_sigs;
  assign unused_sigs = ^{sck_s, cs_rise, cs_fall, mosi_rise, mosi_fall, cmd_next};

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench for spi_ram_bridge: expected RAM accesses and MISO words are queued by the stimulus
// and popped by monitors. Build with SPI_RAM_BURST_EN to exercise streaming bursts.
`timescale 1ns/1ps
module tb_spi_ram_bridge;

  localparam int HALF = 100;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, spi_cs, busy;

  always #5 clk = ~clk;

  spi_ram_bridge_if ram_if ();

  spi_ram_bridge dut (
    .clk_i(clk), .rst_n_i(rst_n), .sck_i(sck), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso), .spi_cs_o(spi_cs), .busy_o(busy), .ram(ram_if)
  );

  int checks = 0;
  int failures = 0;

  acc_t        acc_exp[$];
  logic [31:0] rd_exp[$];
  logic [31:0] rd_obs[$];

  logic [31:0] mem[32];
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  assign ram_if.ram_rdata = mem[ram_if.ram_addr];

  always @(negedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_if.ram_clk && ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // RAM access monitor + MISO word monitor
  acc_t        e;
  logic [31:0] o;
  logic        prev_ram_clk = 1'b0;
  always @(negedge clk) begin
    if (rst_n && ram_if.ram_clk) begin
      check("pulse_width", {63'd0, prev_ram_clk}, 64'd0);
      if (acc_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access we=%b addr=%h data=%h",
                 ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wdata);
      end else begin
        e = acc_exp.pop_front();
        check("acc_we", {63'd0, ram_if.ram_we}, {63'd0, e.we});
        check("acc_addr", {59'd0, ram_if.ram_addr}, {59'd0, e.addr});
        if (e.we) check("acc_data", {32'd0, ram_if.ram_wdata}, {32'd0, e.data});
      end
    end
    prev_ram_clk = rst_n && ram_if.ram_clk;
    if (rd_obs.size() > 0) begin
      o = rd_obs.pop_front();
      if (rd_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_miso_word actual=%h", o);
      end else begin
        check("miso_word", {32'd0, o}, {32'd0, rd_exp.pop_front()});
      end
    end
  end

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic push_acc(input logic we, input logic [4:0] a, input logic [31:0] d);
    acc_t t;
    t.we = we;
    t.addr = a;
    t.data = d;
    acc_exp.push_back(t);
  endtask

  // Mode 0 master: MOSI set while SCK low, MISO sampled just before each rising edge.
  task automatic spi_frame(input logic [7:0] cmd, input logic [63:0] data, input int nbits,
                           input bit collect);
    logic [31:0] word;
    @(negedge clk);
    #2;
    cs_n = 1'b0;
    #(HALF);
    for (int i = 7; i >= 0; i--) begin
      mosi = cmd[i];
      #(HALF);
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
    end
    word = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[63-i];
      #(HALF);
      word = {word[30:0], miso};
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
      if (collect && (i % 32) == 31) rd_obs.push_back(word);
    end
    mosi = 1'b0;
    #(HALF);
    cs_n = 1'b1;
    #(4*HALF);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    #23;
    check("rst_ram_clk", {63'd0, ram_if.ram_clk}, 64'd0);
    check("rst_ram_we", {63'd0, ram_if.ram_we}, 64'd0);
    check("rst_ram_addr", {59'd0, ram_if.ram_addr}, 64'd0);
    check("rst_ram_data", {32'd0, ram_if.ram_wdata}, 64'd0);
    check("rst_miso", {63'd0, miso}, 64'd0);
    check("rst_spi_cs", {63'd0, spi_cs}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    #20 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single write
    push_acc(1'b1, 5'd1, 32'hDEADBEEF);
    spi_frame(8'h81, {32'hDEADBEEF, 32'h0}, 32, 1'b0);

    // 2: read, plus readback of word 1 with ignored cmd bits 6:5 set
    load(5'd5, 32'h12345678);
    push_acc(1'b0, 5'd5, 32'h0);
    rd_exp.push_back(32'h12345678);
    spi_frame(8'h05, 64'h0, 32, 1'b1);
    push_acc(1'b0, 5'd1, 32'h0);
    rd_exp.push_back(32'hDEADBEEF);
    spi_frame(8'h61, 64'h0, 32, 1'b1);

    // 3: abort after 20 data bits, then a clean frame and readback
    spi_frame(8'h81, {32'hAAAAAAAA, 32'h0}, 20, 1'b0);
    push_acc(1'b1, 5'd3, 32'h0000CAFE);
    spi_frame(8'h83, {32'h0000CAFE, 32'h0}, 32, 1'b0);
    push_acc(1'b0, 5'd3, 32'h0);
    rd_exp.push_back(32'h0000CAFE);
    spi_frame(8'h03, 64'h0, 32, 1'b1);

    // 4: async reset while the RAM pulse is high
    push_acc(1'b1, 5'd7, 32'h55AA55AA);
    fork
      spi_frame(8'h87, {32'h55AA55AA, 32'h0}, 32, 1'b0);
    join_none
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (ram_if.ram_clk) found = 1'b1;
    end
    check("pulse_seen", {63'd0, found}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ram_clk", {63'd0, ram_if.ram_clk}, 64'd0);
    check("arst_ram_we", {63'd0, ram_if.ram_we}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    #(10*HALF);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_spi_cs", {63'd0, spi_cs}, 64'd0);
    push_acc(1'b0, 5'd3, 32'h0);
    rd_exp.push_back(32'h0000CAFE);
    spi_frame(8'h03, 64'h0, 32, 1'b1);

    // 5: write at the top address (burst wraps to 0)
`ifdef SPI_RAM_BURST_EN
    push_acc(1'b1, 5'd31, 32'h0000000A);
    push_acc(1'b1, 5'd0, 32'h0000000B);
    spi_frame(8'h9F, {32'h0000000A, 32'h0000000B}, 64, 1'b0);
`else
    push_acc(1'b1, 5'd31, 32'h0000000A);
    spi_frame(8'h9F, {32'h0000000A, 32'h0000000B}, 64, 1'b0);
`endif

    // 6: two-word read at the top address
    load(5'd31, 32'h00000011);
    load(5'd0, 32'h00000022);
    push_acc(1'b0, 5'd31, 32'h0);
    rd_exp.push_back(32'h00000011);
`ifdef SPI_RAM_BURST_EN
    push_acc(1'b0, 5'd0, 32'h0);
    push_acc(1'b0, 5'd1, 32'h0);
    rd_exp.push_back(32'h00000022);
`else
    rd_exp.push_back(32'h00000000);
`endif
    spi_frame(8'h1F, 64'h0, 64, 1'b1);

    repeat (20) @(negedge clk);
    check("acc_queue_drained", 64'(acc_exp.size()), 64'd0);
    check("rd_queue_drained", 64'(rd_exp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
